// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - shared MDU opcodes, FSM states, decoder control fields and op-class helpers
package mdu_iter_pkg;

    localparam int W_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    typedef struct packed {
        logic    is_mdu;
        mdu_op_t mdu_op;
    } control_t;

    function automatic logic op_is_w(input mdu_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic op_sext_w(input mdu_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic op_is_mul(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic op_mul_high(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic op_a_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic op_b_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division iteration on unsigned magnitudes
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor keeps the trial difference inside (-2^XLEN, 2^XLEN), so the top bit is the borrow
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV64M multiply/divide unit; MDU_EARLY_OUT_EN enables early multiply exit
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int AW = XLEN + MUL_STEP;
    localparam logic signed [W_WIDTH-1:0] MIN_32 = 32'sh8000_0000;
    localparam logic [XLEN-1:0] MIN_W = XLEN'(MIN_32);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_q, state_d;
    mdu_op_t           op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ~v + 1'b1 : v;
    endfunction

    function automatic logic [XLEN-1:0] w_fix(input logic [XLEN-1:0] v, input logic w);
        logic signed [W_WIDTH-1:0] lo;
        lo = v[W_WIDTH-1:0];
        if (w) return XLEN'(lo);
        return v;
    endfunction

    // Accept-side operand preparation and divide special cases
    mdu_op_t                   op_in;
    logic                      in_w, in_a_neg, in_b_neg, div_zero, div_ovf;
    logic signed [W_WIDTH-1:0] a_lo, b_lo;
    logic [XLEN-1:0]           a_pre, b_pre, dvd_init, special_res;

    always_comb begin
        op_in = mdu_op_t'(op);
        in_w  = op_is_w(op_in);
        a_lo  = a[W_WIDTH-1:0];
        b_lo  = b[W_WIDTH-1:0];
        a_pre = a;
        b_pre = b;
        if (in_w && op_sext_w(op_in)) begin
            a_pre = XLEN'(a_lo);
            b_pre = XLEN'(b_lo);
        end else if (in_w) begin
            a_pre = XLEN'(a[W_WIDTH-1:0]);
            b_pre = XLEN'(b[W_WIDTH-1:0]);
        end
        in_a_neg = op_a_signed(op_in) && a_pre[XLEN-1];
        in_b_neg = op_b_signed(op_in) && b_pre[XLEN-1];
        // W dividends fit in 32 bits; pre-align them so 32 iterations consume the right bits
        dvd_init = mag(a_pre, in_a_neg) << (in_w ? XLEN - W_WIDTH : 0);
        div_zero = (b_pre == '0);
        div_ovf  = op_b_signed(op_in) && (a_pre == (in_w ? MIN_W : MIN_X)) && (b_pre == '1);
        if (div_zero) special_res = op_is_rem(op_in) ? a_pre : '1;
        else          special_res = op_is_rem(op_in) ? '0 : a_pre;
        special_res = w_fix(special_res, in_w);
    end

    logic            a_neg, b_neg;
    logic [XLEN-1:0] mcand, dvs;

    assign a_neg = op_a_signed(op_q) && a_q[XLEN-1];
    assign b_neg = op_b_signed(op_q) && b_q[XLEN-1];
    assign mcand = mag(a_q, a_neg);
    assign dvs   = mag(b_q, b_neg);

    // Radix-2^MUL_STEP shift-add; the product register shifts right as multiplier bits retire
    logic [AW-1:0]     addend, mul_sum;
    logic [2*XLEN-1:0] mul_acc, mul_fin;
    logic [XLEN-1:0]   mul_mplr, mul_res;
    logic              mul_last, mul_exit;
    int                mul_iters;

    always_comb begin
        addend = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplr_q[i]) addend = addend + ({{MUL_STEP{1'b0}}, mcand} << i);
        end
        mul_sum   = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + addend;
        mul_acc   = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
        mul_mplr  = mplr_q >> MUL_STEP;
        mul_iters = op_is_w(op_q) ? W_WIDTH / MUL_STEP : XLEN / MUL_STEP;
        mul_last  = (int'(cnt_q) == mul_iters - 1);
`ifdef MDU_EARLY_OUT_EN
        mul_exit  = mul_last || (mul_mplr == '0);
`else
        mul_exit  = mul_last;
`endif
        // Bits not yet consumed still sit below the product; shift them out on exit
        mul_fin = mul_acc >> (XLEN - (int'(cnt_q) + 1) * MUL_STEP);
        if (a_neg ^ b_neg) mul_fin = ~mul_fin + 1'b1;
        mul_res = w_fix(op_mul_high(op_q) ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0], op_is_w(op_q));
    end

    logic [XLEN-1:0] rem_n, quo_n, div_q, div_r, div_res;
    logic            div_last;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (acc_q[2*XLEN-1:XLEN]),
        .quo_i (acc_q[XLEN-1:0]),
        .dvs_i (dvs),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    always_comb begin
        div_last = (int'(cnt_q) == (op_is_w(op_q) ? W_WIDTH : XLEN) - 1);
        div_q    = (a_neg ^ b_neg) ? ~quo_n + 1'b1 : quo_n;
        div_r    = a_neg ? ~rem_n + 1'b1 : rem_n;
        div_res  = w_fix(op_is_rem(op_q) ? div_r : div_q, op_is_w(op_q));
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && !flush) begin
                    op_d  = op_in;
                    a_d   = a_pre;
                    b_d   = b_pre;
                    cnt_d = '0;
                    if (op_is_mul(op_in)) begin
                        state_d = ST_MUL;
                        acc_d   = '0;
                        mplr_d  = mag(b_pre, in_b_neg);
                    end else if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else begin
                        state_d = ST_DIV;
                        acc_d   = {{XLEN{1'b0}}, dvd_init};
                    end
                end
            end
            ST_MUL: begin
                acc_d  = mul_acc;
                mplr_d = mul_mplr;
                cnt_d  = cnt_q + 1'b1;
                if (mul_exit) begin
                    acc_d    = mul_fin;
                    result_d = mul_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_d = {rem_n, quo_n};
                cnt_d = cnt_q + 1'b1;
                if (div_last) begin
                    result_d = div_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed-vector self-checking bench for mdu_iter (XLEN=64, MUL_STEP=2)
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] a, b, result;
    int          n_checks = 0;
    int          n_fail = 0;

    mdu_iter #(.XLEN(64), .MUL_STEP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input mdu_op_t o, input logic [63:0] av, input logic [63:0] bv);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input mdu_op_t o, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] res, input int lat_exp);
        int lat;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        issue(o, av, bv);
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_result"}, result, res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int hits;
        reset = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b0;
        #11;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_op("mul_3_m5",   OP_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33);
        run_op("mulhu_ones", OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("mulh_m1_m1", OP_MULH,   '1, '1, 64'd0, 33);
        run_op("mulhsu_m1_2", OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("mulw_wrap",  OP_MULW,   64'hAAAA_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 17);
        run_op("div_by0",    OP_DIV,    64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_by0",    OP_REM,    64'd7, 64'd0, 64'd7, 1);
        run_op("div_ovf",    OP_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",    OP_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw_ovf",   OP_DIVW,   64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("remw_m7_2",  OP_REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("div_m7_2",   OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("divuw_100_7", OP_DIVUW, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33);

        // backpressure: result held while the consumer stalls
        out_ready = 1'b0;
        issue(OP_DIVU, 64'd100, 64'd7);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", result, 64'd14);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);

        // flush mid-divide
        issue(OP_DIV, 64'd1000, 64'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        hits = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check("flush_no_result", 64'(hits), 64'd0);

        // flush concurrent with a request discards it
        in_valid = 1'b1; op = OP_MUL; a = 64'd5; b = 64'd5; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_req_in_ready", 64'(in_ready), 64'd1);
        check("flush_req_busy", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a multiply
        issue(OP_MUL, 64'd3, 64'd5);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", result, 64'd0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        run_op("mul_after_rst", OP_MUL, 64'd6, 64'd7, 64'd42, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
